// File: rtl/avr_gpio_bank.sv
// Parametrised AVR-style GPIO bank: PORTS ports of WIDTH bits with PIN/DDR/PORT
// registers, two-flop input synchronisers and per-port pin-change interrupts.
module avr_gpio_bank #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PORTS      = 2,
    parameter logic [5:0]  BASE_ADDR  = 6'h03,
    parameter logic [5:0]  PCMSK_ADDR = 6'h20,
    parameter logic [5:0]  PCIFR_ADDR = 6'h1B,
    parameter logic [5:0]  PCICR_ADDR = 6'h28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             io_addr,
    input  logic [7:0]             io_wdata,
    input  logic                   io_we,
    input  logic                   io_re,
    output logic [7:0]             io_rdata,
    output logic                   io_hit,
    input  logic [PORTS*WIDTH-1:0] pin_in,
    output logic [PORTS*WIDTH-1:0] port_out,
    output logic [PORTS*WIDTH-1:0] ddr_out,
    output logic                   irq
);

    // Addresses are compared in 7 bits so that groups running past 6'h3F
    // simply stop decoding instead of wrapping onto low addresses.
    localparam logic [6:0] BASE7 = {1'b0, BASE_ADDR};
    localparam logic [6:0] MSK7  = {1'b0, PCMSK_ADDR};
    localparam logic [6:0] IFR7  = {1'b0, PCIFR_ADDR};
    localparam logic [6:0] ICR7  = {1'b0, PCICR_ADDR};

    logic [PORTS-1:0][WIDTH-1:0] port_q;
    logic [PORTS-1:0][WIDTH-1:0] ddr_q;
    logic [PORTS-1:0][WIDTH-1:0] pcmsk_q;
    logic [PORTS-1:0][WIDTH-1:0] s1_q;
    logic [PORTS-1:0][WIDTH-1:0] s2_q;
    logic [PORTS-1:0][WIDTH-1:0] s3_q;
    logic [PORTS-1:0]            pcifr_q;
    logic [PORTS-1:0]            pcicr_q;
    logic                        irq_q;

    logic [6:0]       addr7;
    logic [PORTS-1:0] pin_sel;
    logic [PORTS-1:0] ddr_sel;
    logic [PORTS-1:0] prt_sel;
    logic [PORTS-1:0] msk_sel;
    logic             pcifr_sel;
    logic             pcicr_sel;
    logic [3:0]       grp_en;
    logic [6:0]       best_addr;

    logic [WIDTH-1:0] wdata_w;
    logic [PORTS-1:0] wdata_p;
    logic [PORTS-1:0] chg;
    logic [PORTS-1:0] pcifr_clr;
    logic [PORTS-1:0] pcifr_next;
    logic [PORTS-1:0] pcicr_next;

    function automatic logic [7:0] pad_w(input logic [WIDTH-1:0] v);
        pad_w = '0;
        pad_w[WIDTH-1:0] = v;
    endfunction

    function automatic logic [7:0] pad_p(input logic [PORTS-1:0] v);
        pad_p = '0;
        pad_p[PORTS-1:0] = v;
    endfunction

    assign addr7     = {1'b0, io_addr};
    assign wdata_w   = io_wdata[WIDTH-1:0];
    assign wdata_p   = io_wdata[PORTS-1:0];
    assign pcifr_sel = (addr7 == IFR7);
    assign pcicr_sel = (addr7 == ICR7);

    always_comb begin
        pin_sel = '0;
        ddr_sel = '0;
        prt_sel = '0;
        msk_sel = '0;
        for (int p = 0; p < PORTS; p++) begin
            pin_sel[p] = (addr7 == BASE7 + 7'(3 * p));
            ddr_sel[p] = (addr7 == BASE7 + 7'(3 * p + 1));
            prt_sel[p] = (addr7 == BASE7 + 7'(3 * p + 2));
            msk_sel[p] = (addr7 == MSK7 + 7'(p));
        end
    end

    // Overlapping regions resolve to the group whose first address is lowest;
    // grp_en is one-hot: 0 port regs, 1 PCMSK, 2 PCIFR, 3 PCICR.
    always_comb begin
        grp_en    = '0;
        best_addr = 7'h7F;
        if (|(pin_sel | ddr_sel | prt_sel)) begin
            grp_en    = 4'b0001;
            best_addr = BASE7;
        end
        if ((|msk_sel) && (MSK7 < best_addr)) begin
            grp_en    = 4'b0010;
            best_addr = MSK7;
        end
        if (pcifr_sel && (IFR7 < best_addr)) begin
            grp_en    = 4'b0100;
            best_addr = IFR7;
        end
        if (pcicr_sel && (ICR7 < best_addr)) begin
            grp_en    = 4'b1000;
        end
    end

    assign io_hit = (|grp_en) && (io_we || io_re);

    always_comb begin
        io_rdata = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (grp_en[0] && pin_sel[p]) io_rdata = io_rdata | pad_w(s2_q[p]);
            if (grp_en[0] && ddr_sel[p]) io_rdata = io_rdata | pad_w(ddr_q[p]);
            if (grp_en[0] && prt_sel[p]) io_rdata = io_rdata | pad_w(port_q[p]);
            if (grp_en[1] && msk_sel[p]) io_rdata = io_rdata | pad_w(pcmsk_q[p]);
        end
        if (grp_en[2]) io_rdata = pad_p(pcifr_q);
        if (grp_en[3]) io_rdata = pad_p(pcicr_q);
    end

    // A change is seen only while s2 and s3 differ, so a mask enabled later
    // cannot pick up an edge that has already passed.
    always_comb begin
        chg = '0;
        for (int p = 0; p < PORTS; p++) begin
            chg[p] = |((s2_q[p] ^ s3_q[p]) & pcmsk_q[p]);
        end
    end

    always_comb begin
        pcifr_clr  = (io_we && grp_en[2]) ? wdata_p : '0;
        pcifr_next = chg | (pcifr_q & ~pcifr_clr);
        pcicr_next = (io_we && grp_en[3]) ? wdata_p : pcicr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_q  <= '0;
            ddr_q   <= '0;
            pcmsk_q <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pcifr_q <= '0;
            pcicr_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            s1_q <= pin_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            for (int p = 0; p < PORTS; p++) begin
                if (io_we && grp_en[0] && ddr_sel[p]) ddr_q[p] <= wdata_w;
                if (io_we && grp_en[0] && prt_sel[p]) port_q[p] <= wdata_w;
                if (io_we && grp_en[0] && pin_sel[p]) port_q[p] <= port_q[p] ^ wdata_w;
                if (io_we && grp_en[1] && msk_sel[p]) pcmsk_q[p] <= wdata_w;
            end
            pcifr_q <= pcifr_next;
            pcicr_q <= pcicr_next;
            irq_q   <= |(pcifr_next & pcicr_next);
        end
    end

    assign port_out = port_q;
    assign ddr_out  = ddr_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avr_gpio_bank.sv
// Scoreboard bench for avr_gpio_bank: stimulus pushes expected results, a
// negedge monitor pops and compares them whenever a read or an observation is presented.
module tb_avr_gpio_bank;

    localparam int WIDTH = 8;
    localparam int PORTS = 2;

    localparam int K_READ = 0;
    localparam int K_PORT = 1;
    localparam int K_DDR  = 2;
    localparam int K_IRQ  = 3;
    localparam int K_RST  = 4;

    typedef struct {
        int          kind;
        string       name;
        logic [16:0] exp;
    } exp_t;

    logic                   clk;
    logic                   reset;
    logic [5:0]             io_addr;
    logic [7:0]             io_wdata;
    logic                   io_we;
    logic                   io_re;
    logic [7:0]             io_rdata;
    logic                   io_hit;
    logic [PORTS*WIDTH-1:0] pin_in;
    logic [PORTS*WIDTH-1:0] port_out;
    logic [PORTS*WIDTH-1:0] ddr_out;
    logic                   irq;

    logic obs_req;
    int   obs_kind;
    exp_t sb_q[$];
    int   checks;
    int   errors;

    avr_gpio_bank #(
        .WIDTH(WIDTH),
        .PORTS(PORTS),
        .BASE_ADDR(6'h03),
        .PCMSK_ADDR(6'h20),
        .PCIFR_ADDR(6'h1B),
        .PCICR_ADDR(6'h28)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_addr(io_addr),
        .io_wdata(io_wdata),
        .io_we(io_we),
        .io_re(io_re),
        .io_rdata(io_rdata),
        .io_hit(io_hit),
        .pin_in(pin_in),
        .port_out(port_out),
        .ddr_out(ddr_out),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] addr, input logic [7:0] data,
                                 input logic we, input logic re);
        @(posedge clk);
        #1;
        io_addr  = addr;
        io_wdata = data;
        io_we    = we;
        io_re    = re;
        obs_req  = 1'b0;
    endtask

    task automatic push_exp(input int kind, input logic [16:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input int kind, input logic [16:0] exp, input string name);
        @(posedge clk);
        #1;
        io_we    = 1'b0;
        io_re    = 1'b0;
        obs_req  = 1'b1;
        obs_kind = kind;
        push_exp(kind, exp, name);
    endtask

    task automatic write_reg(input logic [5:0] addr, input logic [7:0] data);
        applyStimulus(addr, data, 1'b1, 1'b0);
    endtask

    task automatic read_reg(input logic [5:0] addr, input logic hit, input logic [7:0] data,
                            input string name);
        applyStimulus(addr, 8'h00, 1'b0, 1'b1);
        push_exp(K_READ, {8'h00, hit, data}, name);
    endtask

    task automatic set_pins(input logic [PORTS*WIDTH-1:0] v);
        applyStimulus(6'h00, 8'h00, 1'b0, 1'b0);
        pin_in = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(6'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic compare_next(input int kind_now);
        exp_t        e;
        logic [16:0] act;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_output: kind %0d presented with empty scoreboard", kind_now);
        end else begin
            e = sb_q.pop_front();
            case (kind_now)
                K_READ:  act = {8'h00, io_hit, io_rdata};
                K_PORT:  act = {1'b0, port_out};
                K_DDR:   act = {1'b0, ddr_out};
                K_IRQ:   act = {16'h0000, irq};
                default: act = {irq, port_out};
            endcase
            if (e.kind != kind_now) begin
                errors++;
                $display("[TB] FAIL %s: presented kind %0d, expected kind %0d", e.name, kind_now, e.kind);
            end else if (act !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (io_re) compare_next(K_READ);
        if (obs_req) compare_next(obs_kind);
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        io_addr  = 6'h00;
        io_wdata = 8'h00;
        io_we    = 1'b0;
        io_re    = 1'b0;
        obs_req  = 1'b0;
        obs_kind = K_READ;
        pin_in   = 16'hFFFF;

        $display("[TB] reset state");
        idle(2);
        checkOutput(K_PORT, 17'h00000, "rst_port_out");
        checkOutput(K_DDR,  17'h00000, "rst_ddr_out");
        checkOutput(K_IRQ,  17'h00000, "rst_irq");

        @(posedge clk);
        #1;
        reset   = 1'b0;
        obs_req = 1'b0;
        read_reg(6'h03, 1'b1, 8'h00, "pin0_first_edge");
        idle(1);
        read_reg(6'h03, 1'b1, 8'hFF, "pin0_synced");
        read_reg(6'h06, 1'b1, 8'hFF, "pin1_synced");
        read_reg(6'h1B, 1'b1, 8'h00, "pcifr_after_reset");

        $display("[TB] register writes and decode");
        write_reg(6'h04, 8'hF0);
        write_reg(6'h05, 8'hA5);
        checkOutput(K_DDR,  17'h000F0, "ddr0_out");
        checkOutput(K_PORT, 17'h000A5, "port0_out");
        read_reg(6'h05, 1'b1, 8'hA5, "port0_read");
        read_reg(6'h04, 1'b1, 8'hF0, "ddr0_read");
        read_reg(6'h3F, 1'b0, 8'h00, "unmapped_read");

        $display("[TB] PIN-write toggle");
        write_reg(6'h03, 8'h0F);
        checkOutput(K_PORT, 17'h000AA, "toggle_once");
        write_reg(6'h03, 8'h0F);
        checkOutput(K_PORT, 17'h000A5, "toggle_twice");
        read_reg(6'h03, 1'b1, 8'hFF, "pin0_unaffected");
        write_reg(6'h08, 8'h3C);
        checkOutput(K_PORT, 17'h03CA5, "port1_out");
        read_reg(6'h07, 1'b1, 8'h00, "ddr1_read");

        $display("[TB] pin-change interrupt");
        write_reg(6'h21, 8'h01);
        write_reg(6'h28, 8'h02);
        read_reg(6'h21, 1'b1, 8'h01, "pcmsk1_read");
        read_reg(6'h28, 1'b1, 8'h02, "pcicr_read");
        set_pins(16'hFEFF);
        checkOutput(K_IRQ, 17'h00000, "irq_edge_k");
        read_reg(6'h1B, 1'b1, 8'h00, "pcifr_edge_k1");
        checkOutput(K_IRQ, 17'h00001, "irq_edge_k2");
        read_reg(6'h1B, 1'b1, 8'h02, "pcifr_set");

        write_reg(6'h1B, 8'h02);
        checkOutput(K_IRQ, 17'h00000, "irq_cleared");
        set_pins(16'hFCFF);
        idle(3);
        read_reg(6'h1B, 1'b1, 8'h00, "masked_no_flag");
        checkOutput(K_IRQ, 17'h00000, "masked_no_irq");

        $display("[TB] set wins over clear");
        set_pins(16'hFDFF);
        checkOutput(K_IRQ, 17'h00000, "setwin_edge_k");
        write_reg(6'h1B, 8'h02);
        read_reg(6'h1B, 1'b1, 8'h02, "setwin_flag");
        checkOutput(K_IRQ, 17'h00001, "setwin_irq");
        write_reg(6'h1B, 8'h02);
        checkOutput(K_IRQ, 17'h00000, "clear_irq");
        read_reg(6'h1B, 1'b1, 8'h00, "clear_flag");

        $display("[TB] mask is not retroactive");
        set_pins(16'hFFFF);
        idle(3);
        write_reg(6'h21, 8'h03);
        read_reg(6'h1B, 1'b1, 8'h00, "late_mask_no_flag");
        read_reg(6'h21, 1'b1, 8'h03, "pcmsk1_read2");

        $display("[TB] asynchronous reset mid-operation");
        set_pins(16'hFEFF);
        idle(3);
        checkOutput(K_IRQ, 17'h00001, "pre_reset_irq");
        read_reg(6'h1B, 1'b1, 8'h02, "pre_reset_flag");
        @(posedge clk);
        #1;
        reset    = 1'b1;
        io_addr  = 6'h1B;
        io_we    = 1'b0;
        io_re    = 1'b1;
        obs_req  = 1'b1;
        obs_kind = K_RST;
        push_exp(K_READ, {8'h00, 1'b1, 8'h00}, "async_rst_pcifr");
        push_exp(K_RST, 17'h00000, "async_rst_irq_port");
        idle(2);
        reset = 1'b0;
        idle(3);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
